// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
// FSM state encoding, owner encoding, default burst length and the
// beat-index width helper used by dmem_arbiter and dmem_beat_ctr.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_XFER = 2'd1,
    ST_PLY_XFER = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_PLY = 1'b1
  } arb_owner_e;

  localparam int unsigned DMEM_ARB_BEATS = 8;

  // Width of a beat index; never below one bit so ports stay legal.
  function automatic int unsigned beat_idx_w(input int unsigned beats);
    if (beats <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(beats);
    end
  endfunction

endpackage

// File: rtl/dmem_beat_ctr.sv
// dmem_beat_ctr: beat counter for dmem_arbiter transfers.
// Clear has priority over increment. last_o flags the final beat of the
// current transfer: beat BEATS-1 for a burst, beat 0 for a single word.
module dmem_beat_ctr
  import dmem_arb_pkg::*;
#(
  parameter  int unsigned BEATS = DMEM_ARB_BEATS,
  localparam int unsigned BW    = beat_idx_w(BEATS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          burst_i,
  output logic [BW-1:0] beat_o,
  output logic          last_o
);

  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;

  // Next beat index: clear on a new grant, step while beats remain.
  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = {BW{1'b0}};
    end else if (inc_i) begin
      beat_d = beat_q + {{(BW-1){1'b0}}, 1'b1};
    end else begin
      beat_d = beat_q;
    end
  end

  // Beat index register; an in-flight transfer is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= {BW{1'b0}};
    end else begin
      beat_q <= beat_d;
    end
  end

  // Final-beat decode depends on the latched transfer length.
  always_comb begin
    last_o = 1'b0;
    if (burst_i) begin
      last_o = (beat_q == BW'(BEATS - 1));
    end else begin
      last_o = (beat_q == {BW{1'b0}});
    end
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU
// load/store path (single words and BEATS-word bitmap bursts) and the PLY
// note-fetch engine. PLY wins ties; bursts are never preempted.
// Optional feature macro: DMEM_ARB_FAIR_EN -- after a PLY grant the CPU
// wins the next tie, bounding CPU wait to one PLY transfer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W = 16,
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned BEATS  = DMEM_ARB_BEATS,
  localparam int unsigned BW     = beat_idx_w(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_burst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [BW-1:0]     cpu_beat,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              stall,
  input  logic              ply_req,
  input  logic [ADDR_W-1:0] ply_addr,
  output logic              ply_gnt,
  output logic              ply_rvalid,
  output logic [DATA_W-1:0] ply_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              burst_q;
  logic              cpu_rvalid_q;
  logic              ply_rvalid_q;
  logic              cpu_done_q;

  arb_owner_e        winner_s;
  logic              cpu_gnt_s;
  logic              ply_gnt_s;
  logic              cpu_issue_s;
  logic              ply_issue_s;
  logic              fair_cpu_s;
  logic [BW-1:0]     beat_s;
  logic              last_s;

`ifdef DMEM_ARB_FAIR_EN
  logic last_ply_q;

  // Remember who was granted last so the CPU wins the next tie after PLY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ply_q <= 1'b0;
    end else if (ply_gnt_s) begin
      last_ply_q <= 1'b1;
    end else if (cpu_gnt_s) begin
      last_ply_q <= 1'b0;
    end else begin
      last_ply_q <= last_ply_q;
    end
  end

  assign fair_cpu_s = cpu_req && last_ply_q;
`else
  assign fair_cpu_s = 1'b0;
`endif

  assign cpu_issue_s = (state_q == ST_CPU_XFER);
  assign ply_issue_s = (state_q == ST_PLY_XFER);

  // Arbitration in IDLE; grants are combinational and masked in reset.
  always_comb begin
    winner_s  = OWN_CPU;
    cpu_gnt_s = 1'b0;
    ply_gnt_s = 1'b0;
    if (rst_n && (state_q == ST_IDLE) && (cpu_req || ply_req)) begin
      if (ply_req && !fair_cpu_s) begin
        winner_s = OWN_PLY;
      end else begin
        winner_s = OWN_CPU;
      end
      cpu_gnt_s = (winner_s == OWN_CPU);
      ply_gnt_s = (winner_s == OWN_PLY);
    end else begin
      winner_s  = OWN_CPU;
      cpu_gnt_s = 1'b0;
      ply_gnt_s = 1'b0;
    end
  end

  dmem_beat_ctr #(
    .BEATS (BEATS)
  ) u_beat_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cpu_gnt_s || ply_gnt_s),
    .inc_i   (cpu_issue_s && !last_s),
    .burst_i (burst_q),
    .beat_o  (beat_s),
    .last_o  (last_s)
  );

  // Transfer FSM with registered read-valid and done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      we_q         <= 1'b0;
      burst_q      <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ply_rvalid_q <= 1'b0;
      cpu_done_q   <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_issue_s && !we_q;
      ply_rvalid_q <= ply_issue_s;
      cpu_done_q   <= cpu_issue_s && last_s;
      case (state_q)
        ST_IDLE: begin
          if (cpu_gnt_s) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            burst_q <= cpu_burst;
            state_q <= ST_CPU_XFER;
          end else if (ply_gnt_s) begin
            addr_q  <= ply_addr;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            state_q <= ST_PLY_XFER;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CPU_XFER: begin
          if (last_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_CPU_XFER;
          end
        end
        ST_PLY_XFER: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port drive; address adds the beat and wraps at 2^ADDR_W.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    cpu_beat  = {BW{1'b0}};
    case (state_q)
      ST_CPU_XFER: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + ADDR_W'(beat_s);
        mem_wdata = cpu_wdata;
        cpu_beat  = beat_s;
      end
      ST_PLY_XFER: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
      end
      default: begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
      end
    endcase
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign ply_gnt    = ply_gnt_s;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ply_rvalid = ply_rvalid_q;
  assign cpu_done   = cpu_done_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : {DATA_W{1'b0}};
  assign ply_rdata  = ply_rvalid_q ? mem_rdata : {DATA_W{1'b0}};
  assign stall      = rst_n && ((cpu_req && !cpu_gnt_s) || cpu_issue_s);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// single-ported memory. Honors DMEM_ARB_FAIR_EN for the fairness case.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_burst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        cpu_gnt;
  logic [2:0]  cpu_beat;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        stall;
  logic        ply_req = 1'b0;
  logic [15:0] ply_addr = 16'h0000;
  logic        ply_gnt;
  logic        ply_rvalid;
  logic [15:0] ply_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  logic [15:0] mem [0:65535];
  int n_chk = 0;
  int n_bad = 0;

  wire any_out = cpu_gnt | (|cpu_beat) | cpu_rvalid | (|cpu_rdata) | cpu_done |
                 stall | ply_gnt | ply_rvalid | (|ply_rdata) | mem_en | mem_we |
                 (|mem_addr) | (|mem_wdata);

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_burst(cpu_burst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_beat(cpu_beat), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .stall(stall),
    .ply_req(ply_req), .ply_addr(ply_addr), .ply_gnt(ply_gnt),
    .ply_rvalid(ply_rvalid), .ply_rdata(ply_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory: read data one cycle after enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic single_ld(input string tag, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_burst = 1'b0; cpu_addr = a; #1;
    chk({tag, "_gnt"}, cpu_gnt, 1);
    chk({tag, "_gnt_memen"}, mem_en, 0);
    @(negedge clk); cpu_req = 1'b0; #1;
    chk({tag, "_issue_en"}, mem_en, 1);
    chk({tag, "_issue_addr"}, mem_addr, a);
    chk({tag, "_issue_we"}, mem_we, 0);
    chk({tag, "_issue_stall"}, stall, 1);
    chk({tag, "_early_rvalid"}, cpu_rvalid, 0);
    @(negedge clk); #1;
    chk({tag, "_rvalid"}, cpu_rvalid, 1);
    chk({tag, "_rdata"}, cpu_rdata, d);
    chk({tag, "_done"}, cpu_done, 1);
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_memen"}, mem_en, 0);
  endtask

  initial begin
    logic        cpu_seen;
    logic        ply_seen;
    logic        quiet;
    int          cpu_rv_n;
    int          ply_rv_n;
    logic [15:0] ea;

    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h2222;
    mem[16'h0030] = 16'h3333;
    mem[16'h0040] = 16'h4444;
    for (int k = 0; k < 8; k++) mem[16'h0100 + 16'(k)] = 16'h1100 + 16'(k);

    // Reset state
    @(negedge clk); #1;
    chk("rst_outs_zero", any_out, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_release_idle", any_out, 0);

    // Single LD
    single_ld("ld", 16'h0010, 16'hBEEF);

    // STB burst wrapping past 0xFFFF
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b1; cpu_burst = 1'b1; cpu_addr = 16'hFFFC; #1;
    chk("stb_gnt", cpu_gnt, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); cpu_req = 1'b0; cpu_wdata = 16'hA000 + 16'(k); #1;
      ea = 16'hFFFC + 16'(k);
      chk($sformatf("stb_addr%0d", k), mem_addr, ea);
      chk($sformatf("stb_beat%0d", k), cpu_beat, k);
      chk($sformatf("stb_we%0d", k), mem_we, 1);
      chk($sformatf("stb_nodone%0d", k), cpu_done, 0);
      chk($sformatf("stb_stall%0d", k), stall, 1);
    end
    @(negedge clk); #1;
    chk("stb_done", cpu_done, 1);
    chk("stb_no_rvalid", cpu_rvalid, 0);
    chk("stb_done_stall", stall, 0);
    chk("stb_mem_ffff", mem[16'hFFFF], 16'hA003);
    chk("stb_mem_0001", mem[16'h0001], 16'hA005);
    cpu_we = 1'b0; cpu_burst = 1'b0;

    // Simultaneous requests: PLY first, CPU on the ply_rvalid cycle
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0020; ply_req = 1'b1; ply_addr = 16'h0030; #1;
    chk("arb_ply_gnt", ply_gnt, 1);
    chk("arb_cpu_wait", cpu_gnt, 0);
    chk("arb_stall_wait", stall, 1);
    @(negedge clk); ply_req = 1'b0; #1;
    chk("arb_ply_addr", mem_addr, 16'h0030);
    chk("arb_cpu_still_wait", cpu_gnt, 0);
    @(negedge clk); #1;
    chk("arb_ply_rvalid", ply_rvalid, 1);
    chk("arb_ply_rdata", ply_rdata, 16'h3333);
    chk("arb_cpu_gnt", cpu_gnt, 1);
    @(negedge clk); cpu_req = 1'b0; #1;
    chk("arb_cpu_addr", mem_addr, 16'h0020);
    @(negedge clk); #1;
    chk("arb_cpu_rdata", cpu_rdata, 16'h2222);
    chk("arb_cpu_done", cpu_done, 1);

    // Fairness: PLY re-requests while CPU still waits after a PLY grant
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0020; ply_req = 1'b1; ply_addr = 16'h0030; #1;
    chk("fair_first_ply", ply_gnt, 1);
    @(negedge clk); ply_req = 1'b0; #1;
    @(negedge clk); ply_req = 1'b1; ply_addr = 16'h0040; #1;
    chk("fair_cpu_gnt", cpu_gnt, FAIR);
    chk("fair_ply_gnt", ply_gnt, !FAIR);
    cpu_seen = cpu_gnt; ply_seen = ply_gnt; quiet = 1'b0;
    cpu_rv_n = 0; ply_rv_n = 0;
    for (int i = 0; i < 30 && !quiet; i++) begin
      @(negedge clk);
      if (cpu_seen) cpu_req = 1'b0;
      if (ply_seen) ply_req = 1'b0;
      #1;
      cpu_seen = cpu_gnt; ply_seen = ply_gnt;
      if (cpu_rvalid) begin cpu_rv_n++; chk("fair_cpu_rdata", cpu_rdata, 16'h2222); end
      if (ply_rvalid) begin ply_rv_n++; chk("fair_ply_rdata", ply_rdata, 16'h4444); end
      if (!cpu_req && !ply_req && !mem_en && !cpu_rvalid && !ply_rvalid && !stall) quiet = 1'b1;
    end
    chk("fair_drained", quiet, 1);
    chk("fair_cpu_rv_count", cpu_rv_n, 1);
    chk("fair_ply_rv_count", ply_rv_n, 1);

    // PLY request raised mid-LDB waits for the burst to finish
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_burst = 1'b1; cpu_addr = 16'h0100; #1;
    chk("ldb_gnt", cpu_gnt, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); cpu_req = 1'b0;
      if (k == 2) begin ply_req = 1'b1; ply_addr = 16'h0040; end
      #1;
      chk($sformatf("ldb_addr%0d", k), mem_addr, 16'h0100 + 16'(k));
      chk($sformatf("ldb_beat%0d", k), cpu_beat, k);
      chk($sformatf("ldb_no_ply_gnt%0d", k), ply_gnt, 0);
      if (k > 0) chk($sformatf("ldb_rdata%0d", k - 1), cpu_rdata, 16'h1100 + 16'(k - 1));
    end
    @(negedge clk); #1;
    chk("ldb_done", cpu_done, 1);
    chk("ldb_last_rvalid", cpu_rvalid, 1);
    chk("ldb_last_rdata", cpu_rdata, 16'h1107);
    chk("ldb_ply_gnt", ply_gnt, 1);
    chk("ldb_done_stall", stall, 0);
    @(negedge clk); ply_req = 1'b0; cpu_burst = 1'b0; #1;
    chk("ldb_ply_addr", mem_addr, 16'h0040);
    @(negedge clk); #1;
    chk("ldb_ply_rvalid", ply_rvalid, 1);
    chk("ldb_ply_rdata", ply_rdata, 16'h4444);

    // Reset during beat 3 of a burst
    @(negedge clk); cpu_req = 1'b1; cpu_burst = 1'b1; cpu_addr = 16'h0100; #1;
    chk("rstb_gnt", cpu_gnt, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cpu_req = 1'b0; #1;
    end
    chk("rstb_beat3", cpu_beat, 3);
    rst_n = 1'b0; #1;
    chk("rstb_outs_zero", any_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rstb_hold_zero%0d", i), any_out, 0);
    end
    @(negedge clk); rst_n = 1'b1; cpu_burst = 1'b0; #1;
    chk("rstb_release_zero", any_out, 0);
    @(negedge clk); #1;
    chk("rstb_no_late_done", any_out, 0);
    single_ld("post_rst_ld", 16'h0010, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
